bcd_disp_drv: RTL

- Output-side counterpart to the keypad adder: takes the adder's 12-bit binary result and drives a 4-digit multiplexed common-anode 7-segment display.
- Converts binary to BCD sequentially (shift-add-3, one bit per clock) and holds the converted digits.
- Scans the four digits continuously, driving one anode at a time.
- Sits between the adder result register and the board display pins.

---
 rtl/bcd_disp_drv.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_disp_drv.sv
// bcd_disp_drv: binary-to-BCD converter and 4-digit multiplexed 7-segment driver.
//
// A binary value is converted to BCD with shift-add-3, one bit per clock. The
// result is held in the digit registers. The four digits are scanned
// continuously onto a common-anode display, one anode at a time.
//
// Parameters:
//   IN_W      width of the binary input (1..13)
//   SCAN_DIV  clocks per digit slot (>= 2)
//
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   value  binary number to display
//   valid  load strobe, sampled only while busy=0
//   busy   conversion in progress
//   done   one-cycle pulse when the new digits are latched for display
//   seg    segments {g,f,e,d,c,b,a}, active low
//   an     digit anodes, active low, one-hot, an[0] = units
//
// Optional feature macro: BCD_DISP_DRV_LZB_EN enables leading-zero blanking.
// Blanked digits keep their anode slot, so the scan timing does not change.

module bcd_disp_drv #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned SCAN_DIV = 6750
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] value,
  input  logic            valid,
  output logic            busy,
  output logic            done,
  output logic [6:0]      seg,
  output logic [3:0]      an
);

  localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned PreW = $clog2(SCAN_DIV);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] bin_q;
  logic [15:0]     bcd_q;
  logic [15:0]     bcd_adj;
  logic [15:0]     bcd_shift;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     digits_q;
  logic            done_q;
  logic            accept;
  logic            last;
  logic            cnt_last;

  logic [PreW-1:0] presc_q;
  logic [1:0]      idx_q;
  logic [6:0]      seg_q, seg_nxt;
  logic [3:0]      an_q;
  logic [3:0]      cur_digit;
  logic [3:0]      blank;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign cnt_last = (cnt_q == CntW'(IN_W - 1));

  // Conversion FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Conversion FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid) state_d = StShift;
      StShift: if (cnt_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Conversion FSM: outputs
  always_comb begin
    busy   = (state_q == StShift);
    accept = (state_q == StIdle) && valid;
    last   = (state_q == StShift) && cnt_last;
  end

  // Shift-add-3 step: correct nibbles >= 5, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[14:0], bin_q[IN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        bin_q <= value;
        bcd_q <= '0;
        cnt_q <= '0;
      end else if (busy) begin
        bin_q <= bin_q << 1;
        bcd_q <= bcd_shift;
        cnt_q <= cnt_q + CntW'(1);
      end
      // The final shift result goes straight to the display registers.
      if (last) begin
        digits_q <= bcd_shift;
      end
    end
  end

  // Digit selection and optional leading-zero blanking
  always_comb begin
    cur_digit = 4'd0;
    unique case (idx_q)
      2'd0: cur_digit = digits_q[3:0];
      2'd1: cur_digit = digits_q[7:4];
      2'd2: cur_digit = digits_q[11:8];
      2'd3: cur_digit = digits_q[15:12];
      default: cur_digit = 4'd0;
    endcase

    blank = 4'b0000;
`ifdef BCD_DISP_DRV_LZB_EN
    blank[3] = (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
    blank[0] = 1'b0;
`endif

    seg_nxt = blank[idx_q] ? 7'h7F : encode(cur_digit);
  end

  // Free-running scan; an and seg are registered together from the same index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
    end else begin
      if (presc_q == PreW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + PreW'(1);
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= seg_nxt;
    end
  end

  assign done = done_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
